// File: rtl/otl_axi_pkg.sv
// Shared constants and FSM encoding for the OTL AXI4-Lite master bridge.
package otl_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WR_B  = 3'd2,
    RD_A  = 3'd3,
    RD_R  = 3'd4,
    RSP   = 3'd5,
    DRAIN = 3'd6
  } state_t;

endpackage

// File: rtl/otl_axi_master_wdog.sv
// Response wait counter: cleared on state entry, counts while enabled, flags expiry at TIMEOUT-1.
module otl_axi_master_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/otl_axi_master.sv
// AXI4-Lite master bridge: one local read/write command becomes one AXI4-Lite transaction.
// Optional response timeout with drain of the late beat: define OTL_AXI_MASTER_TIMEOUT_EN.
module otl_axi_master
  import otl_axi_pkg::*;
#(
  parameter int unsigned ADDRW   = 32,
  parameter int unsigned DATAW   = 32,
  parameter logic [2:0]  PROT    = PROT_DEFAULT,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic               m_axi_aclk,
  input  logic               m_axi_areset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDRW-1:0]   cmd_addr,
  input  logic [DATAW-1:0]   cmd_wdata,
  input  logic [DATAW/8-1:0] cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_write,
  output logic [DATAW-1:0]   rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic [ADDRW-1:0]   m_axi_awaddr,
  output logic [2:0]         m_axi_awprot,
  output logic               m_axi_awvalid,
  input  logic               m_axi_awready,
  output logic [DATAW-1:0]   m_axi_wdata,
  output logic [DATAW/8-1:0] m_axi_wstrb,
  output logic               m_axi_wvalid,
  input  logic               m_axi_wready,
  input  logic [1:0]         m_axi_bresp,
  input  logic               m_axi_bvalid,
  output logic               m_axi_bready,
  output logic [ADDRW-1:0]   m_axi_araddr,
  output logic [2:0]         m_axi_arprot,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [DATAW-1:0]   m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready
);

  localparam int unsigned STRBW = DATAW / 8;

  if ((DATAW != 32 && DATAW != 64) || TIMEOUT < 2) begin : g_param_check
    $error("otl_axi_master: DATAW must be 32 or 64 and TIMEOUT at least 2");
  end

  state_t             state, state_nxt;
  logic [ADDRW-1:0]   addr, addr_nxt;
  logic [DATAW-1:0]   wdata, wdata_nxt;
  logic [STRBW-1:0]   wstrb, wstrb_nxt;
  logic               awvalid, awvalid_nxt;
  logic               wvalid, wvalid_nxt;
  logic               bready, bready_nxt;
  logic               arvalid, arvalid_nxt;
  logic               rready, rready_nxt;
  logic               aw_done, aw_done_nxt;
  logic               w_done, w_done_nxt;
  logic               rsp_valid_r, rsp_valid_nxt;
  logic               rsp_write_r, rsp_write_nxt;
  logic [DATAW-1:0]   rsp_rdata_r, rsp_rdata_nxt;
  logic [1:0]         rsp_resp_r, rsp_resp_nxt;
  logic               aw_hs, w_hs;

  assign aw_hs = awvalid & m_axi_awready;
  assign w_hs  = wvalid & m_axi_wready;

`ifdef OTL_AXI_MASTER_TIMEOUT_EN
  logic drain_pend, drain_pend_nxt;
  logic expire;
  logic late_beat;

  assign late_beat = (bready & m_axi_bvalid) | (rready & m_axi_rvalid);

  otl_axi_master_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (m_axi_aclk),
    .rst    (m_axi_areset),
    .clear  (state_nxt != state),
    .enable ((state == WR_B) || (state == RD_R)),
    .expire (expire)
  );
`endif

  // Next-state and next-register values
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    wstrb_nxt     = wstrb;
    awvalid_nxt   = awvalid;
    wvalid_nxt    = wvalid;
    bready_nxt    = bready;
    arvalid_nxt   = arvalid;
    rready_nxt    = rready;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    rsp_valid_nxt = rsp_valid_r;
    rsp_write_nxt = rsp_write_r;
    rsp_rdata_nxt = rsp_rdata_r;
    rsp_resp_nxt  = rsp_resp_r;
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
    drain_pend_nxt = drain_pend;
`endif

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_nxt      = cmd_addr;
          wdata_nxt     = cmd_wdata;
          wstrb_nxt     = cmd_wstrb;
          rsp_write_nxt = cmd_write;
          if (cmd_write) begin
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
            state_nxt   = WR;
          end else begin
            arvalid_nxt = 1'b1;
            state_nxt   = RD_A;
          end
        end
      end

      // AW and W finish independently; B is only requested once both are in
      WR: begin
        if (aw_hs) awvalid_nxt = 1'b0;
        if (w_hs)  wvalid_nxt  = 1'b0;
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          bready_nxt  = 1'b1;
          state_nxt   = WR_B;
        end else begin
          aw_done_nxt = aw_done | aw_hs;
          w_done_nxt  = w_done | w_hs;
        end
      end

      WR_B: begin
        if (m_axi_bvalid) begin
          rsp_resp_nxt  = m_axi_bresp;
          rsp_rdata_nxt = '0;
          bready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
        else if (expire) begin
          rsp_resp_nxt   = RESP_DECERR;
          rsp_rdata_nxt  = '0;
          rsp_valid_nxt  = 1'b1;
          drain_pend_nxt = 1'b1;
          state_nxt      = RSP;
        end
`endif
      end

      RD_A: begin
        if (m_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end

      RD_R: begin
        if (m_axi_rvalid) begin
          rsp_resp_nxt  = m_axi_rresp;
          rsp_rdata_nxt = m_axi_rdata;
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
        else if (expire) begin
          rsp_resp_nxt   = RESP_DECERR;
          rsp_rdata_nxt  = '0;
          rsp_valid_nxt  = 1'b1;
          drain_pend_nxt = 1'b1;
          state_nxt      = RSP;
        end
`endif
      end

      RSP: begin
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
        // A late beat may land while the timeout response is still pending
        if (drain_pend && late_beat) begin
          bready_nxt     = 1'b0;
          rready_nxt     = 1'b0;
          drain_pend_nxt = 1'b0;
        end
`endif
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
          if (drain_pend_nxt) state_nxt = DRAIN;
`endif
        end
      end

`ifdef OTL_AXI_MASTER_TIMEOUT_EN
      DRAIN: begin
        if (late_beat) begin
          bready_nxt     = 1'b0;
          rready_nxt     = 1'b0;
          drain_pend_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
`endif

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state       <= IDLE;
      addr        <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= '0;
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
      drain_pend  <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      wdata       <= wdata_nxt;
      wstrb       <= wstrb_nxt;
      awvalid     <= awvalid_nxt;
      wvalid      <= wvalid_nxt;
      bready      <= bready_nxt;
      arvalid     <= arvalid_nxt;
      rready      <= rready_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_write_r <= rsp_write_nxt;
      rsp_rdata_r <= rsp_rdata_nxt;
      rsp_resp_r  <= rsp_resp_nxt;
`ifdef OTL_AXI_MASTER_TIMEOUT_EN
      drain_pend  <= drain_pend_nxt;
`endif
    end
  end

  assign cmd_ready     = (state == IDLE) & ~m_axi_areset;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_write     = rsp_write_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign m_axi_awaddr  = addr;
  assign m_axi_awprot  = PROT;
  assign m_axi_awvalid = awvalid;
  assign m_axi_wdata   = wdata;
  assign m_axi_wstrb   = wstrb;
  assign m_axi_wvalid  = wvalid;
  assign m_axi_bready  = bready;
  assign m_axi_araddr  = addr;
  assign m_axi_arprot  = PROT;
  assign m_axi_arvalid = arvalid;
  assign m_axi_rready  = rready;

endmodule

// File: tb/tb_otl_axi_master.sv
// Randomized bench for otl_axi_master: the bench plays the AXI4-Lite slave with a memory model.
module tb_otl_axi_master;
  import otl_axi_pkg::*;

  logic        clk = 1'b0;
  logic        m_axi_areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  otl_axi_master #(
    .ADDRW(32), .DATAW(32), .PROT(3'b000), .TIMEOUT(8)
  ) dut (
    .m_axi_aclk(clk), .m_axi_areset(m_axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] pick_resp();
    int r;
    r = int'($urandom_range(0, 3));
    return (r == 2) ? RESP_SLVERR : (r == 3) ? RESP_DECERR : RESP_OKAY;
  endfunction

  task automatic idle_slave();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = 32'h0;
    rsp_ready = 1'b0;
  endtask

  // One command end to end; dly_a = AW/AR wait, dly_w = W wait, dly_r = B/R wait after address phase
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int dly_a, input int dly_w,
                         input int dly_r, input logic [1:0] resp, input int hold);
    int k, aw_k, w_k, ar_k, b_k, r_k, rsp_k, aw_seen, w_seen, ar_seen, hs_k, exp_k;
    logic [31:0] exp_rdata, got_rdata;
    logic [1:0]  got_resp;
    logic        got_write;
    logic [7:0]  bad;
    bit          done;
    exp_rdata = wr ? 32'h0 : mem_rd(a);
    exp_k = wr ? 3 + ((dly_a > dly_w) ? dly_a : dly_w) + dly_r : 3 + dly_a + dly_r;
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    aw_k = 0; w_k = 0; ar_k = 0; b_k = 0; r_k = 0; rsp_k = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; bad = '0; done = 0; k = 1;
    got_rdata = '0; got_resp = '0; got_write = 1'b0;
    while (!done && k <= 300) begin
      if (cmd_ready) bad[0] = 1'b1;
      if (wr) begin
        if (m_axi_arvalid || m_axi_rready) bad[1] = 1'b1;
        if (m_axi_awvalid) begin
          if (aw_k != 0) bad[2] = 1'b1;
          m_axi_awready = (aw_seen >= dly_a); aw_seen++;
          if (m_axi_awready) begin
            aw_k = k;
            check("awaddr", 64'(m_axi_awaddr), 64'(a));
            check("awprot", 64'(m_axi_awprot), 64'(3'b000));
          end
        end else begin
          m_axi_awready = 1'b0;
          if (aw_k == 0) bad[2] = 1'b1;
        end
        if (m_axi_wvalid) begin
          if (w_k != 0) bad[2] = 1'b1;
          m_axi_wready = (w_seen >= dly_w); w_seen++;
          if (m_axi_wready) begin
            w_k = k;
            check("wdata", 64'(m_axi_wdata), 64'(d));
            check("wstrb", 64'(m_axi_wstrb), 64'(s));
          end
        end else begin
          m_axi_wready = 1'b0;
          if (w_k == 0) bad[2] = 1'b1;
        end
        hs_k = (aw_k > w_k) ? aw_k : w_k;
        if (aw_k != 0 && w_k != 0 && hs_k < k && b_k == 0) begin
          m_axi_bvalid = (k - hs_k - 1 >= dly_r); m_axi_bresp = resp;
          if (m_axi_bvalid && m_axi_bready) b_k = k;
        end else begin
          if (m_axi_bready) bad[3] = 1'b1;
          m_axi_bvalid = 1'b0;
        end
      end else begin
        if (m_axi_awvalid || m_axi_wvalid || m_axi_bready) bad[1] = 1'b1;
        if (m_axi_arvalid) begin
          if (ar_k != 0) bad[2] = 1'b1;
          m_axi_arready = (ar_seen >= dly_a); ar_seen++;
          if (m_axi_arready) begin
            ar_k = k;
            check("araddr", 64'(m_axi_araddr), 64'(a));
            check("arprot", 64'(m_axi_arprot), 64'(3'b000));
          end
        end else begin
          m_axi_arready = 1'b0;
          if (ar_k == 0) bad[2] = 1'b1;
        end
        if (ar_k != 0 && ar_k < k && r_k == 0) begin
          m_axi_rvalid = (k - ar_k - 1 >= dly_r); m_axi_rresp = resp; m_axi_rdata = exp_rdata;
          if (m_axi_rvalid && m_axi_rready) r_k = k;
        end else begin
          if (m_axi_rready) bad[3] = 1'b1;
          m_axi_rvalid = 1'b0;
        end
      end
      if (rsp_valid) begin
        if (rsp_k == 0) begin
          rsp_k = k; got_write = rsp_write; got_rdata = rsp_rdata; got_resp = rsp_resp;
        end else if ({rsp_write, rsp_rdata, rsp_resp} != {got_write, got_rdata, got_resp}) begin
          bad[5] = 1'b1;
        end
        rsp_ready = (k - rsp_k >= hold);
        if (rsp_ready) done = 1;
      end else begin
        rsp_ready = 1'b0;
        if (rsp_k != 0) bad[6] = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    idle_slave();
    if (!done) check("txn_timeout", 64'(0), 64'(1));
    check("rsp_latency", 64'(rsp_k), 64'(exp_k));
    check("rsp_write", 64'(got_write), 64'(wr));
    check("rsp_rdata", 64'(got_rdata), 64'(exp_rdata));
    check("rsp_resp", 64'(got_resp), 64'(resp));
    if (wr) begin
      check("aw_hs_cycle", 64'(aw_k), 64'(1 + dly_a));
      check("w_hs_cycle", 64'(w_k), 64'(1 + dly_w));
    end else begin
      check("ar_hs_cycle", 64'(ar_k), 64'(1 + dly_a));
    end
    check("protocol_flags", 64'(bad), 64'(0));
    check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    check("rsp_valid_after", 64'(rsp_valid), 64'(0));
    if (wr && resp == RESP_OKAY) mem[a] = merge(mem_rd(a), d, s);
  endtask

  task automatic reset_in_wr_b();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFEF00D;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("rst_pre_bready", 64'(m_axi_bready), 64'(1));
    m_axi_areset = 1'b1;
    @(negedge clk);
    check("rst_bready", 64'(m_axi_bready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_rready}), 64'(0));
    check("rst_cmd_ready_held", 64'(cmd_ready), 64'(0));
    m_axi_areset = 1'b0;
    #1;
    check("rst_cmd_ready_release", 64'(cmd_ready), 64'(1));
  endtask

`ifdef OTL_AXI_MASTER_TIMEOUT_EN
  task automatic read_timeout();
    int k, first;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
    @(negedge clk);
    cmd_valid = 1'b0; m_axi_arready = 1'b1;
    first = 0;
    for (k = 1; k <= 40 && first == 0; k++) begin
      if (rsp_valid) first = k;
      @(negedge clk);
      m_axi_arready = 1'b0;
    end
    check("to_latency", 64'(first), 64'(10));
    check("to_resp", 64'(rsp_resp), 64'(RESP_DECERR));
    check("to_rdata", 64'(rsp_rdata), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("to_drain_rready", 64'(m_axi_rready), 64'(1));
    check("to_drain_cmd_ready", 64'(cmd_ready), 64'(0));
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h55AA55AA;
    @(negedge clk);
    m_axi_rvalid = 1'b0;
    check("to_rready_drop", 64'(m_axi_rready), 64'(0));
    check("to_rsp_quiet", 64'(rsp_valid), 64'(0));
    check("to_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    bit wr;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    idle_slave();
    m_axi_areset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'(0));
    check("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                               m_axi_arvalid, m_axi_rready, rsp_valid}), 64'(0));
    check("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    check("reset_rsp_resp", 64'(rsp_resp), 64'(0));
    check("reset_awaddr", 64'(m_axi_awaddr), 64'(0));
    m_axi_areset = 1'b0;

    mem[32'h24] = 32'h12345678;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, RESP_OKAY, 0);
    run_txn(1'b0, 32'h24, 32'h0, 4'h0, 3, 0, 0, RESP_OKAY, 0);
    run_txn(1'b1, 32'h28, 32'hA5A5_5A5A, 4'h5, 5, 0, 0, RESP_OKAY, 0);
    run_txn(1'b0, 32'h24, 32'h0, 4'h0, 0, 0, 1, RESP_SLVERR, 4);
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 0, RESP_OKAY, 0);
    reset_in_wr_b();

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      a  = {26'h0, 4'($urandom), 2'b00};
      d  = $urandom;
      run_txn(wr, a, d, 4'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), pick_resp(), int'($urandom_range(0, 3)));
    end

`ifdef OTL_AXI_MASTER_TIMEOUT_EN
    read_timeout();
    run_txn(1'b0, 32'h10, 32'h0, 4'h0, 1, 0, 2, RESP_OKAY, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
